// File: rtl/m_store_buffer.sv
// Posted-write store buffer between the memory stage and data memory.
// Drains in order, forwards to younger loads, stalls on partial overlap.
module m_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic        st_byte,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [31:0] st_pc,
    output logic        st_ready,
    input  logic        ld_valid,
    input  logic        ld_byte,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic [31:0] ld_data,
    output logic        ld_stall,
    input  logic        dm_grant,
    output logic        dm_we,
    output logic        dm_byte,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic [31:0] dm_pc,
    output logic        empty
);

    logic [DEPTH-1:0] e_byte;
    logic [31:0]      e_addr [DEPTH];
    logic [31:0]      e_data [DEPTH];
    logic [31:0]      e_pc   [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    logic push;
    logic pop;

    assign st_ready = (count < (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push     = st_valid & st_ready;
    assign pop      = (count != '0) & dm_grant;

    assign dm_we   = pop;
    assign dm_byte = pop ? e_byte[head] : 1'b0;
    assign dm_addr = pop ? e_addr[head] : '0;
    assign dm_wd   = pop ? e_data[head] : '0;
    assign dm_pc   = pop ? e_pc[head]   : '0;

    logic          found;
    logic [PW-1:0] sel;
    logic [PW-1:0] idx;
    logic [7:0]    lane;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        found = 1'b0;
        sel   = head;
        idx   = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (((PW+1)'(i) < count) &&
                (e_addr[idx][31:2] == ld_addr[31:2])) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        lane = '0;
        case (ld_addr[1:0])
            2'd0: lane = e_data[sel][7:0];
            2'd1: lane = e_data[sel][15:8];
            2'd2: lane = e_data[sel][23:16];
            2'd3: lane = e_data[sel][31:24];
            default: lane = '0;
        endcase
    end

    always_comb begin
        ld_hit   = 1'b0;
        ld_stall = 1'b0;
        ld_data  = '0;
        if (ld_valid && found) begin
            if (!e_byte[sel]) begin
                ld_hit  = 1'b1;
                ld_data = ld_byte ? {24'b0, lane} : e_data[sel];
            end else if (ld_byte &&
                         (e_addr[sel][1:0] == ld_addr[1:0])) begin
                ld_hit  = 1'b1;
                ld_data = {24'b0, e_data[sel][7:0]};
            end else begin
                ld_stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            e_byte <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_addr[i] <= '0;
                e_data[i] <= '0;
                e_pc[i]   <= '0;
            end
        end else begin
            if (push) begin
                e_byte[tail] <= st_byte;
                e_addr[tail] <= st_addr;
                e_data[tail] <= st_data;
                e_pc[tail]   <= st_pc;
                tail         <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

endmodule

// File: tb/tb_m_store_buffer.sv
// Bench for m_store_buffer: scoreboard of expected data-memory writes
// plus per-scenario forwarding, stall and reset checks.
module tb_m_store_buffer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_byte;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [31:0] st_pc;
    logic        st_ready;
    logic        ld_valid;
    logic        ld_byte;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        dm_grant;
    logic        dm_we;
    logic        dm_byte;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_pc;
    logic        empty;

    typedef struct packed {
        logic        b;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] p;
    } wr_t;

    wr_t sb[$];
    int  vectors;
    int  miscompares;
    bit  allow_full;

    m_store_buffer #(.DEPTH(4), .PW(2)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_byte(st_byte), .st_addr(st_addr),
        .st_data(st_data), .st_pc(st_pc), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_addr(ld_addr),
        .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
        .dm_grant(dm_grant), .dm_we(dm_we), .dm_byte(dm_byte),
        .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_pc(dm_pc),
        .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_st(input logic b, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] p,
                          input bit expect_accept);
        st_valid = 1'b1;
        st_byte  = b;
        st_addr  = a;
        st_data  = d;
        st_pc    = p;
        if (expect_accept) sb.push_back({b, a, d, p});
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (reset && st_valid && !allow_full) begin
                vectors++;
                if (st_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL protocol_store_while_full: st_ready=%b want 1", st_ready);
                end
            end
            if (reset && dm_we) begin
                vectors++;
                if (!dm_grant) begin
                    miscompares++;
                    $display("FAIL dm_we_without_grant: dm_we=%b want 0", dm_we);
                end else if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: addr=%h wd=%h pc=%h want no write", dm_addr, dm_wd, dm_pc);
                end else begin
                    e = sb.pop_front();
                    if ({dm_byte, dm_addr, dm_wd, dm_pc} !== e) begin
                        miscompares++;
                        $display("FAIL drain_order: got b=%b a=%h d=%h p=%h want b=%b a=%h d=%h p=%h",
                                 dm_byte, dm_addr, dm_wd, dm_pc, e.b, e.a, e.d, e.p);
                    end
                end
            end
        end
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        @(negedge clk);
        while (!empty && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (empty !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_timeout: empty=%b want 1", empty);
        end
        next();
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        ld_valid = 1'b1;
        ld_byte  = 1'b0;
        ld_addr  = 32'h0;
        dm_grant = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({st_ready, empty, dm_we, dm_byte, dm_addr, dm_wd, dm_pc,
             ld_hit, ld_data, ld_stall} !== {3'b110, 1'b0, 96'h0, 1'b0, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: rdy=%b emp=%b we=%b a=%h hit=%b d=%h stl=%b want rdy=1 emp=1 rest 0",
                     st_ready, empty, dm_we, dm_addr, ld_hit, ld_data, ld_stall);
        end
        next();
        reset    = 1'b1;
        ld_valid = 1'b0;
        next();
    endtask

    task automatic test_single_drain();
        dm_grant = 1'b1;
        set_st(1'b0, 32'h10, 32'h1234_5678, 32'h3000, 1'b1);
        @(negedge clk);
        vectors++;
        if (dm_we !== 1'b0) begin
            miscompares++;
            $display("FAIL same_cycle_drain: dm_we=%b want 0", dm_we);
        end
        next();
        st_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({dm_we, dm_addr, dm_wd, dm_pc} !== {1'b1, 32'h10, 32'h1234_5678, 32'h3000}) begin
            miscompares++;
            $display("FAIL first_drain: we=%b a=%h d=%h p=%h want 1 10 12345678 3000",
                     dm_we, dm_addr, dm_wd, dm_pc);
        end
        next();
        @(negedge clk);
        vectors++;
        if ({empty, dm_we} !== 2'b10) begin
            miscompares++;
            $display("FAIL empty_after_drain: empty=%b we=%b want 1 0", empty, dm_we);
        end
        next();
    endtask

    task automatic test_fill_wrap();
        dm_grant = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_st(1'b0, 32'(k * 4), $urandom, 32'h100 + 32'(k), 1'b1);
            next();
        end
        st_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({st_ready, empty} !== 2'b00) begin
            miscompares++;
            $display("FAIL full_flag: st_ready=%b empty=%b want 0 0", st_ready, empty);
        end
        next();
        dm_grant   = 1'b1;
        allow_full = 1'b1;
        set_st(1'b0, 32'h20, 32'hCAFE_0020, 32'h200, 1'b0);
        @(negedge clk);
        vectors++;
        if ({st_ready, dm_we, dm_addr} !== {2'b01, 32'h0}) begin
            miscompares++;
            $display("FAIL full_refuse: st_ready=%b we=%b a=%h want 0 1 0", st_ready, dm_we, dm_addr);
        end
        next();
        allow_full = 1'b0;
        sb.push_back({1'b0, 32'h20, 32'hCAFE_0020, 32'h200});
        next();
        st_valid = 1'b0;
        wait_empty();
        dm_grant = 1'b0;
    endtask

    task automatic test_word_forward();
        dm_grant = 1'b0;
        set_st(1'b0, 32'h40, 32'hAABB_CCDD, 32'h500, 1'b1);
        ld_valid = 1'b1;
        ld_byte  = 1'b0;
        ld_addr  = 32'h40;
        @(negedge clk);
        vectors++;
        if ({ld_hit, ld_stall, ld_data} !== {2'b00, 32'h0}) begin
            miscompares++;
            $display("FAIL same_cycle_forward: hit=%b stall=%b d=%h want 0 0 0", ld_hit, ld_stall, ld_data);
        end
        next();
        st_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({ld_hit, ld_stall, ld_data} !== {2'b10, 32'hAABB_CCDD}) begin
            miscompares++;
            $display("FAIL word_forward: hit=%b stall=%b d=%h want 1 0 aabbccdd", ld_hit, ld_stall, ld_data);
        end
        next();
        ld_byte = 1'b1;
        ld_addr = 32'h42;
        @(negedge clk);
        vectors++;
        if ({ld_hit, ld_stall, ld_data} !== {2'b10, 32'h0000_00BB}) begin
            miscompares++;
            $display("FAIL byte_from_word: hit=%b stall=%b d=%h want 1 0 000000bb", ld_hit, ld_stall, ld_data);
        end
        next();
    endtask

    task automatic test_youngest();
        set_st(1'b0, 32'h80, 32'h1111_1111, 32'h600, 1'b1);
        next();
        set_st(1'b0, 32'h80, 32'h2222_2222, 32'h604, 1'b1);
        next();
        st_valid = 1'b0;
        ld_byte  = 1'b0;
        ld_addr  = 32'h80;
        @(negedge clk);
        vectors++;
        if ({ld_hit, ld_data} !== {1'b1, 32'h2222_2222}) begin
            miscompares++;
            $display("FAIL youngest_match: hit=%b d=%h want 1 22222222", ld_hit, ld_data);
        end
        next();
        ld_addr = 32'h40;
        @(negedge clk);
        vectors++;
        if ({ld_hit, ld_data} !== {1'b1, 32'hAABB_CCDD}) begin
            miscompares++;
            $display("FAIL older_entry: hit=%b d=%h want 1 aabbccdd", ld_hit, ld_data);
        end
        next();
        ld_addr = 32'h84;
        @(negedge clk);
        vectors++;
        if ({ld_hit, ld_stall, ld_data} !== {2'b00, 32'h0}) begin
            miscompares++;
            $display("FAIL no_match: hit=%b stall=%b d=%h want 0 0 0", ld_hit, ld_stall, ld_data);
        end
        next();
        ld_valid = 1'b0;
        dm_grant = 1'b1;
        wait_empty();
        dm_grant = 1'b0;
    endtask

    task automatic test_partial_stall();
        dm_grant = 1'b0;
        set_st(1'b1, 32'h101, 32'h0000_005A, 32'h700, 1'b1);
        next();
        st_valid = 1'b0;
        ld_valid = 1'b1;
        ld_byte  = 1'b0;
        ld_addr  = 32'h100;
        @(negedge clk);
        vectors++;
        if ({ld_stall, ld_hit} !== 2'b10) begin
            miscompares++;
            $display("FAIL stall_word_on_byte: stall=%b hit=%b want 1 0", ld_stall, ld_hit);
        end
        next();
        ld_byte = 1'b1;
        ld_addr = 32'h102;
        @(negedge clk);
        vectors++;
        if ({ld_stall, ld_hit} !== 2'b10) begin
            miscompares++;
            $display("FAIL stall_other_lane: stall=%b hit=%b want 1 0", ld_stall, ld_hit);
        end
        next();
        ld_addr = 32'h101;
        @(negedge clk);
        vectors++;
        if ({ld_stall, ld_hit, ld_data} !== {2'b01, 32'h0000_005A}) begin
            miscompares++;
            $display("FAIL byte_same_lane: stall=%b hit=%b d=%h want 0 1 0000005a", ld_stall, ld_hit, ld_data);
        end
        next();
        ld_byte  = 1'b0;
        ld_addr  = 32'h100;
        dm_grant = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ld_stall, dm_we, dm_byte} !== 3'b111) begin
            miscompares++;
            $display("FAIL stall_during_drain: stall=%b we=%b byte=%b want 1 1 1", ld_stall, dm_we, dm_byte);
        end
        next();
        @(negedge clk);
        vectors++;
        if ({ld_stall, ld_hit, empty} !== 3'b001) begin
            miscompares++;
            $display("FAIL stall_release: stall=%b hit=%b empty=%b want 0 0 1", ld_stall, ld_hit, empty);
        end
        next();
        ld_valid = 1'b0;
        dm_grant = 1'b0;
    endtask

    task automatic test_async_reset();
        dm_grant = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_st(1'b0, 32'h200 + 32'(k * 4), 32'hD000_0000 + 32'(k), 32'h800 + 32'(k), 1'b1);
            next();
        end
        st_valid = 1'b0;
        dm_grant = 1'b1;
        @(negedge clk);
        vectors++;
        if ({dm_we, dm_addr} !== {1'b1, 32'h200}) begin
            miscompares++;
            $display("FAIL pre_reset_drain: we=%b a=%h want 1 200", dm_we, dm_addr);
        end
        next();
        #2;
        reset    = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 32'h204;
        #1;
        vectors++;
        if ({dm_we, empty, st_ready, ld_hit, ld_stall} !== 5'b01100) begin
            miscompares++;
            $display("FAIL async_reset: we=%b empty=%b rdy=%b hit=%b stall=%b want 0 1 1 0 0",
                     dm_we, empty, st_ready, ld_hit, ld_stall);
        end
        sb.delete();
        next();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if ({dm_we, empty, ld_hit} !== 3'b010) begin
                miscompares++;
                $display("FAIL post_reset_idle: we=%b empty=%b hit=%b want 0 1 0", dm_we, empty, ld_hit);
            end
            next();
        end
        ld_valid = 1'b0;
        dm_grant = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        allow_full  = 1'b0;
        reset       = 1'b0;
        st_valid    = 1'b0;
        st_byte     = 1'b0;
        st_addr     = '0;
        st_data     = '0;
        st_pc       = '0;
        ld_valid    = 1'b0;
        ld_byte     = 1'b0;
        ld_addr     = '0;
        dm_grant    = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_single_drain();
        test_fill_wrap();
        test_word_forward();
        test_youngest();
        test_partial_stall();
        test_async_reset();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover: pending=%0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
